// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter for the secondary port.
// It sends one command byte with the host-request protocol and drives the pins
// through open-drain enables. It reports success on tx_done and failure on tx_error.
// Optional feature: define PS2_TX_ACK_CHECK_EN to turn a missing device
// acknowledge into tx_error. When it is undefined, the ACK bit is not examined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PS2_CLK2,
  input  logic       PS2_DAT2,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int START_CYCLES = 16;
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(START_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shift;
  logic             clk_p0, clk_p1, clk_p2;
  logic             dat_p0, dat_p1;
  logic             fe_p2;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             dat_p2;
`endif
  logic             accept;
  logic             cnt_last;

  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = ~tx_ready;
  assign accept   = tx_valid & tx_ready;
  // The counter reaches zero on the edge that follows a value of one.
  assign cnt_last = (cnt == CNT_ONE);

  // Pin synchronizers and registered falling-edge detect. They idle high, so a reset never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
      fe_p2  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      dat_p2 <= 1'b1;
`endif
    end else begin
      // stage p0 -> p1: two-flop synchronizer
      clk_p0 <= PS2_CLK2;
      dat_p0 <= PS2_DAT2;
      clk_p1 <= clk_p0;
      dat_p1 <= dat_p0;
      // stage p1 -> p2: previous clock value, edge strobe, data aligned with the strobe
      clk_p2 <= clk_p1;
      fe_p2  <= clk_p2 & ~clk_p1;
`ifdef PS2_TX_ACK_CHECK_EN
      dat_p2 <= dat_p1;
`endif
    end
  end

  // Frame shift register: stop, odd parity, data; shifted out LSB first on device clock falls.
  always_ff @(posedge clock) begin
    if (accept)
      shift <= {1'b1, ~^tx_data, tx_data};
    else if (state == S_BITS && fe_p2)
      shift <= {1'b0, shift[9:1]};
  end

  // Transfer sequencer with registered line enables and result pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (accept) begin
            ps2_clk_oe <= 1'b1;
            cnt        <= INHIBIT_LOAD;
            bit_cnt    <= '0;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt_last) begin
            ps2_dat_oe <= 1'b1;
            cnt        <= START_LOAD;
            state      <= S_START;
          end
        end
        S_START: begin
          cnt <= cnt - CNT_ONE;
          if (cnt_last) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= TIMEOUT_LOAD;
            state      <= S_BITS;
          end
        end
        default: begin
          // Watchdog shared by every device-clocked state.
          if (fe_p2)
            cnt <= TIMEOUT_LOAD;
          else
            cnt <= cnt - CNT_ONE;
          if (!fe_p2 && cnt_last) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_IDLE;
          end else begin
            case (state)
              S_BITS: begin
                if (fe_p2) begin
                  ps2_dat_oe <= ~shift[0];
                  bit_cnt    <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd9)
                    state <= S_ACK;
                end
              end
              S_ACK: begin
                if (fe_p2) begin
`ifdef PS2_TX_ACK_CHECK_EN
                  if (dat_p2) begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_error   <= 1'b1;
                    state      <= S_IDLE;
                  end else begin
                    state <= S_WAIT_IDLE;
                  end
`else
                  state <= S_WAIT_IDLE;
`endif
                end
              end
              S_WAIT_IDLE: begin
                if (clk_p1 && dat_p1) begin
                  tx_done <= 1'b1;
                  state   <= S_IDLE;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx.
// A behavioural PS/2 device clocks the host frame and samples it on rising edges.
// Delays are scaled down so that each transfer takes about a thousand cycles.
module tb_ps2_host_tx;

  localparam int I  = 40;    // INHIBIT_CYCLES
  localparam int T  = 3000;  // TIMEOUT_CYCLES
  localparam int HP = 50;    // device clock half period in system cycles

  logic       clock = 1'b0;
  logic       reset;
  logic       PS2_CLK2, PS2_DAT2;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       dev_clk_low, dev_dat_low;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;

  // Open-drain wired-AND of host and device.
  assign PS2_CLK2 = ~(ps2_clk_oe | dev_clk_low);
  assign PS2_DAT2 = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(I), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .PS2_CLK2(PS2_CLK2), .PS2_DAT2(PS2_DAT2),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clock = ~clock;

  // Pulse counters for the result outputs.
  always @(negedge clock) begin
    if (tx_done)             n_done <= n_done + 1;
    if (tx_error)            n_err  <= n_err + 1;
    if (tx_done && tx_error) n_both <= n_both + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [9:0] line;     // {stop, parity, d7..d0}
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for the host to release the clock with the start bit on
  // the data line, then produce n_edges clock pulses (11 includes the ack pulse).
  task automatic dev_xfer(input logic do_ack, input int n_edges,
                          output logic start_bit, output logic [9:0] line, output logic ok);
    ok = 1'b0;
    line = '0;
    start_bit = 1'b1;
    for (int t = 0; t < I + 400; t++) begin
      cyc(1);
      if (PS2_CLK2 === 1'b1 && PS2_DAT2 === 1'b0 && tx_busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    start_bit = PS2_DAT2;
    cyc(HP);
    for (int i = 0; i < n_edges && i < 10; i++) begin
      dev_clk_low = 1'b1;
      cyc(HP);
      dev_clk_low = 1'b0;
      line[i] = PS2_DAT2;
      cyc(HP);
    end
    if (n_edges > 10) begin
      if (do_ack) dev_dat_low = 1'b1;
      cyc(HP / 2);
      dev_clk_low = 1'b1;
      cyc(HP);
      dev_clk_low = 1'b0;
      cyc(5);
      dev_dat_low = 1'b0;
    end
  endtask

  // Wait until a new done or error pulse has been counted.
  task automatic wait_end(input string name, input int base);
    int k;
    k = 0;
    while ((n_done + n_err) <= base && k < T + 500) begin
      cyc(1);
      k++;
    end
    if ((n_done + n_err) <= base) begin
      bad++;
      total++;
      $display("FAIL %s: no completion within %0d cycles", name, T + 500);
    end
    cyc(2);
  endtask

  initial begin
    logic       sb, ok, found;
    logic [9:0] line;
    int         d0, e0, t, t2;

    vecs[0] = '{8'hED, 1'b1, 10'b1_1_11101101, 1'b1, 1'b0};
    vecs[1] = '{8'hF4, 1'b1, 10'b1_0_11110100, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 10'b1_1_00000000, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 10'b1_1_11111111, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b1, 10'b1_1_01010101, 1'b1, 1'b0};
`ifdef PS2_TX_ACK_CHECK_EN
    vecs[5] = '{8'h01, 1'b0, 10'b1_0_00000001, 1'b0, 1'b1};
`else
    vecs[5] = '{8'h01, 1'b0, 10'b1_0_00000001, 1'b1, 1'b0};
`endif

    reset = 1'b1;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    cyc(3);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_dat_oe", ps2_dat_oe, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_error", tx_error, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    reset = 1'b0;
    cyc(3);

    // Table: full transfers with the device model.
    for (int i = 0; i < 6; i++) begin
      d0 = n_done;
      e0 = n_err;
      start_tx(vecs[i].data);
      dev_xfer(vecs[i].ack, 11, sb, line, ok);
      check($sformatf("v%0d_release", i), ok, 1'b1);
      wait_end($sformatf("v%0d_end", i), d0 + e0);
      check($sformatf("v%0d_start", i), sb, 1'b0);
      check($sformatf("v%0d_line", i), line, vecs[i].line);
      check($sformatf("v%0d_done", i), n_done - d0, vecs[i].exp_done);
      check($sformatf("v%0d_err", i), n_err - e0, vecs[i].exp_err);
      check($sformatf("v%0d_oe", i), {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check($sformatf("v%0d_ready", i), tx_ready, 1'b1);
      cyc(10);
    end

    // Inhibit and start timing, measured from the accept edge.
    d0 = n_done;
    e0 = n_err;
    start_tx(8'hF4);
    check("inh_clk_pin", PS2_CLK2, 1'b0);
    check("inh_busy", tx_busy, 1'b1);
    t = 1;
    while (!ps2_dat_oe && t < I + 100) begin cyc(1); t++; end
    check("inh_len", t, I + 1);
    while (ps2_clk_oe && t < I + 200) begin cyc(1); t++; end
    check("start_len", t, I + 17);
    dev_xfer(1'b1, 11, sb, line, ok);
    wait_end("inh_end", d0 + e0);
    check("inh_line", line, 10'b1_0_11110100);
    check("inh_done", n_done - d0, 1);

    // Device never clocks: watchdog fires T cycles after the clock release.
    d0 = n_done;
    e0 = n_err;
    start_tx(8'h3C);
    t = 1;
    while (ps2_clk_oe && t < I + 200) begin cyc(1); t++; end
    t2 = 0;
    while (!tx_error && t2 < T + 200) begin cyc(1); t2++; end
    check("tmo_len", t2, T);
    cyc(2);
    check("tmo_err", n_err - e0, 1);
    check("tmo_done", n_done - d0, 0);
    check("tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("tmo_ready", tx_ready, 1'b1);
    cyc(10);

    // Reset after four device edges; d3 of 0x12 is 0, so data is being pulled low.
    d0 = n_done;
    e0 = n_err;
    start_tx(8'h12);
    dev_xfer(1'b1, 4, sb, line, ok);
    check("rstm_bits", line[3:0], 4'b0010);
    check("rstm_pre_dat", ps2_dat_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rstm_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rstm_ready", tx_ready, 1'b1);
    cyc(3);
    reset = 1'b0;
    cyc(20);
    check("rstm_pulses", (n_done - d0) + (n_err - e0), 0);
    start_tx(8'h55);
    dev_xfer(1'b1, 11, sb, line, ok);
    wait_end("rstm_end", d0 + e0);
    check("rstm_line", line, 10'b1_1_01010101);
    check("rstm_done", n_done - d0, 1);
    cyc(10);

    // Back-to-back: 0xAA held on tx_valid during a 0xED transfer.
    d0 = n_done;
    e0 = n_err;
    tx_data = 8'hED;
    tx_valid = 1'b1;
    cyc(1);
    tx_data = 8'hAA;
    dev_xfer(1'b1, 11, sb, line, ok);
    check("b2b_line1", line, 10'b1_1_11101101);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (tx_done) begin found = 1'b1; break; end
      cyc(1);
    end
    check("b2b_done_seen", found, 1'b1);
    check("b2b_ready_in_done", tx_ready, 1'b1);
    cyc(1);
    check("b2b_accepted", tx_busy, 1'b1);
    check("b2b_clk_oe", ps2_clk_oe, 1'b1);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 11, sb, line, ok);
    wait_end("b2b_end", d0 + e0 + 1);
    check("b2b_line2", line, 10'b1_1_10101010);
    check("b2b_done", n_done - d0, 2);
    check("b2b_err", n_err - e0, 0);

    check("never_both", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
